// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// Programmable VGA/DAC timing generator with host pixel-request look-ahead and built-in test patterns.
// One register stage: video outputs at t+1 reflect the counters at t; oRequest leads active video by REQ_LATENCY.
module vga_timing_gen #(
  parameter int CW          = 10,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACT       = 640,
  parameter int H_FP        = 16,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACT       = 480,
  parameter int V_FP        = 10,
  parameter int H_POL       = 0,
  parameter int V_POL       = 0,
  parameter int REQ_LATENCY = 0,
  parameter int BAR_W       = 80,
  parameter int CHK_LOG2    = 5
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic [1:0]    iMode,
  input  logic [CW-1:0] iRed,
  input  logic [CW-1:0] iGreen,
  input  logic [CW-1:0] iBlue,
  output logic          oRequest,
  output logic [CW-1:0] oVGA_R,
  output logic [CW-1:0] oVGA_G,
  output logic [CW-1:0] oVGA_B,
  output logic          oVGA_H_SYNC,
  output logic          oVGA_V_SYNC,
  output logic          oVGA_BLANK,
  output logic          oVGA_SYNC,
  output logic          oVGA_CLOCK,
  output logic          oDE,
  output logic [11:0]   oX,
  output logic [11:0]   oY,
  output logic          oFrameStart
);

  localparam logic [11:0] L_H_TOT = 12'(H_SYNC + H_BP + H_ACT + H_FP);
  localparam logic [11:0] L_H_AS  = 12'(H_SYNC + H_BP);
  localparam logic [11:0] L_H_AE  = 12'(H_SYNC + H_BP + H_ACT);
  localparam logic [11:0] L_H_SY  = 12'(H_SYNC);
  localparam logic [11:0] L_V_TOT = 12'(V_SYNC + V_BP + V_ACT + V_FP);
  localparam logic [11:0] L_V_AS  = 12'(V_SYNC + V_BP);
  localparam logic [11:0] L_V_AE  = 12'(V_SYNC + V_BP + V_ACT);
  localparam logic [11:0] L_V_SY  = 12'(V_SYNC);
  localparam logic [11:0] L_LAT   = 12'(REQ_LATENCY);
  localparam logic [11:0] L_BAR_W = 12'(BAR_W);
  localparam logic        L_HPOL  = (H_POL != 0);
  localparam logic        L_VPOL  = (V_POL != 0);

  logic [11:0]   r_h_cnt, r_v_cnt;
  logic [1:0]    r_mode;
  logic [11:0]   r_bar_cnt;
  logic [2:0]    r_bar_idx;
  logic          r_hs, r_vs, r_de, r_fs;
  logic [11:0]   r_x, r_y;
  logic [CW-1:0] r_red, r_grn, r_blu;

  logic          w_h_wrap, w_v_wrap, w_origin, w_h_act, w_v_act, w_de, w_chk;
  logic [11:0]   w_x, w_y, w_h_req;
  logic [CW-1:0] w_red, w_grn, w_blu;

  assign w_h_wrap = (r_h_cnt == L_H_TOT - 12'd1);
  assign w_v_wrap = (r_v_cnt == L_V_TOT - 12'd1);
  assign w_origin = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
  assign w_h_act  = (r_h_cnt >= L_H_AS) && (r_h_cnt < L_H_AE);
  assign w_v_act  = (r_v_cnt >= L_V_AS) && (r_v_cnt < L_V_AE);
  assign w_de     = w_h_act && w_v_act;
  assign w_x      = w_de ? (r_h_cnt - L_H_AS) : 12'd0;
  assign w_y      = w_de ? (r_v_cnt - L_V_AS) : 12'd0;
  assign w_chk    = w_x[CHK_LOG2] ^ w_y[CHK_LOG2];

  // Request runs REQ_LATENCY clocks ahead of the pixel it fetches, so it never crosses a line.
  assign w_h_req  = r_h_cnt + L_LAT;
  assign oRequest = (w_h_req >= L_H_AS) && (w_h_req < L_H_AE) && w_v_act;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_mode  <= '0;
    end else begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_wrap ? 12'd0 : r_v_cnt + 12'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 12'd1;
      end
      if (w_origin) r_mode <= iMode;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (!w_h_act) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (r_bar_cnt == L_BAR_W - 12'd1) begin
      r_bar_cnt <= '0;
      if (r_bar_idx != 3'd7) r_bar_idx <= r_bar_idx + 3'd1;
    end else begin
      r_bar_cnt <= r_bar_cnt + 12'd1;
    end
  end

  // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
  always_comb begin
    w_red = '0;
    w_grn = '0;
    w_blu = '0;
    if (w_de) begin
      case (r_mode)
        2'd0: begin
          w_red = iRed;
          w_grn = iGreen;
          w_blu = iBlue;
        end
        2'd1: begin
          w_red = {CW{~r_bar_idx[1]}};
          w_grn = {CW{~r_bar_idx[2]}};
          w_blu = {CW{~r_bar_idx[0]}};
        end
        2'd2: begin
          w_red = {CW{w_chk}};
          w_grn = {CW{w_chk}};
          w_blu = {CW{w_chk}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_hs  <= ~L_HPOL;
      r_vs  <= ~L_VPOL;
      r_de  <= 1'b0;
      r_fs  <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_red <= '0;
      r_grn <= '0;
      r_blu <= '0;
    end else begin
      r_hs  <= (r_h_cnt < L_H_SY) ? L_HPOL : ~L_HPOL;
      r_vs  <= (r_v_cnt < L_V_SY) ? L_VPOL : ~L_VPOL;
      r_de  <= w_de;
      r_fs  <= w_origin;
      r_x   <= w_x;
      r_y   <= w_y;
      r_red <= w_red;
      r_grn <= w_grn;
      r_blu <= w_blu;
    end
  end

  assign oVGA_R      = r_red;
  assign oVGA_G      = r_grn;
  assign oVGA_B      = r_blu;
  assign oVGA_H_SYNC = r_hs;
  assign oVGA_V_SYNC = r_vs;
  assign oDE         = r_de;
  assign oVGA_BLANK  = r_de;
  assign oX          = r_x;
  assign oY          = r_y;
  assign oFrameStart = r_fs;
  assign oVGA_SYNC   = 1'b0;
  assign oVGA_CLOCK  = iCLK;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen: default timing + host latency, reduced timing against a per-cycle model, pattern table.
module tb_vga_timing_gen;

  typedef struct { int due; logic [9:0] val; } sched_t;
  typedef struct { int frame; int x; int y; logic [1:0] mode; logic [29:0] rgb; } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_s_n;
  int n_chk = 0;
  int n_err = 0;

  // u_def: default 640x480 timing, REQ_LATENCY=2
  logic [1:0] d_mode;
  logic [9:0] d_r, d_g, d_b, d_vr, d_vg, d_vb;
  logic d_req, d_hs, d_vs, d_blank, d_sync, d_vclk, d_de, d_fs;
  logic [11:0] d_x, d_y;
  // u_small: reduced timing, positive syncs
  logic [1:0] s_mode;
  logic [9:0] s_r, s_g, s_b, s_vr, s_vg, s_vb;
  logic s_req, s_hs, s_vs, s_blank, s_sync, s_vclk, s_de, s_fs;
  logic [11:0] s_x, s_y;
  // u_bar: full-width lines, short frames, pattern checks
  logic [1:0] b_mode;
  logic [9:0] b_r, b_g, b_b, b_vr, b_vg, b_vb;
  logic b_req, b_hs, b_vs, b_blank, b_sync, b_vclk, b_de, b_fs;
  logic [11:0] b_x, b_y;

  vga_timing_gen #(.REQ_LATENCY(2)) u_def (
    .iCLK(clk), .iRST_N(rst_n), .iMode(d_mode), .iRed(d_r), .iGreen(d_g), .iBlue(d_b),
    .oRequest(d_req), .oVGA_R(d_vr), .oVGA_G(d_vg), .oVGA_B(d_vb),
    .oVGA_H_SYNC(d_hs), .oVGA_V_SYNC(d_vs), .oVGA_BLANK(d_blank), .oVGA_SYNC(d_sync),
    .oVGA_CLOCK(d_vclk), .oDE(d_de), .oX(d_x), .oY(d_y), .oFrameStart(d_fs));

  vga_timing_gen #(.H_SYNC(4), .H_BP(4), .H_ACT(16), .H_FP(4), .V_SYNC(1), .V_BP(1), .V_ACT(8),
                   .V_FP(1), .H_POL(1), .V_POL(1), .REQ_LATENCY(3), .BAR_W(2), .CHK_LOG2(1)) u_small (
    .iCLK(clk), .iRST_N(rst_s_n), .iMode(s_mode), .iRed(s_r), .iGreen(s_g), .iBlue(s_b),
    .oRequest(s_req), .oVGA_R(s_vr), .oVGA_G(s_vg), .oVGA_B(s_vb),
    .oVGA_H_SYNC(s_hs), .oVGA_V_SYNC(s_vs), .oVGA_BLANK(s_blank), .oVGA_SYNC(s_sync),
    .oVGA_CLOCK(s_vclk), .oDE(s_de), .oX(s_x), .oY(s_y), .oFrameStart(s_fs));

  vga_timing_gen #(.V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1)) u_bar (
    .iCLK(clk), .iRST_N(rst_n), .iMode(b_mode), .iRed(b_r), .iGreen(b_g), .iBlue(b_b),
    .oRequest(b_req), .oVGA_R(b_vr), .oVGA_G(b_vg), .oVGA_B(b_vb),
    .oVGA_H_SYNC(b_hs), .oVGA_V_SYNC(b_vs), .oVGA_BLANK(b_blank), .oVGA_SYNC(b_sync),
    .oVGA_CLOCK(b_vclk), .oDE(b_de), .oX(b_x), .oY(b_y), .oFrameStart(b_fs));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference for the reduced-timing instance: H 4/4/16/4 (28), V 1/1/8/1 (11), syncs active-high.
  function automatic logic [60:0] small_model(input int k, input logic [1:0] m,
                                              input logic [9:0] ir, input logic [9:0] ig, input logic [9:0] ib);
    int h, v, idx;
    logic hs, vs, de, fs, c;
    logic [11:0] x, y;
    logic [9:0] r, g, b;
    logic [2:0] bars [8];
    bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    h = k % 28;
    v = (k / 28) % 11;
    hs = (h < 4);
    vs = (v < 1);
    de = (h >= 8) && (h < 24) && (v >= 2) && (v < 10);
    x = de ? 12'(h - 8) : 12'd0;
    y = de ? 12'(v - 2) : 12'd0;
    fs = (h == 0) && (v == 0);
    r = '0; g = '0; b = '0;
    if (de) begin
      case (m)
        2'd0: begin r = ir; g = ig; b = ib; end
        2'd1: begin
          idx = int'(x) / 2;
          if (idx > 7) idx = 7;
          r = {10{bars[idx][2]}};
          g = {10{bars[idx][1]}};
          b = {10{bars[idx][0]}};
        end
        2'd2: begin
          c = x[1] ^ y[1];
          r = {10{c}}; g = {10{c}}; b = {10{c}};
        end
        default: ;
      endcase
    end
    return {hs, vs, de, de, 1'b0, r, g, b, x, y, 1'b0, fs};
  endfunction

  function automatic logic small_req(input int k);
    int h, v;
    h = k % 28;
    v = (k / 28) % 11;
    return (h + 3 >= 8) && (h + 3 < 24) && (v >= 2) && (v < 10);
  endfunction

  task automatic proc_def();
    int hs_lo1 = -1, hs_hi1 = -1, hs_lo2 = -1, vs_cnt = 0, fs_cnt = 0, fs_first = -1;
    int de_cnt = 0, de_first = -1, req_cnt = 0, req_first = -1, rx_bad = 0, blank_bad = 0;
    int col = 0, last_x = -1;
    logic [23:0] first_xy = '1;
    sched_t q[$];
    for (int k = 1; k <= 28820; k++) begin
      @(posedge clk); #1;
      if (!d_hs) begin
        if (hs_lo1 < 0) hs_lo1 = k;
        else if (hs_hi1 >= 0 && hs_lo2 < 0) hs_lo2 = k;
      end else if (hs_lo1 >= 0 && hs_hi1 < 0) hs_hi1 = k;
      if (!d_vs) vs_cnt++;
      if (d_fs) begin fs_cnt++; if (fs_first < 0) fs_first = k; end
      if (d_de) begin
        de_cnt++;
        if (de_first < 0) begin de_first = k; first_xy = {d_x, d_y}; end
        if (12'(d_vr) != d_x) rx_bad++;
        last_x = int'(d_x);
      end
      if (d_blank != d_de) blank_bad++;
      if (d_req) begin req_cnt++; if (req_first < 0) req_first = k; end
      // Host: returns the column index two clocks after each request, junk otherwise.
      if (k % 800 == 0) col = 0;
      if (d_req) begin q.push_back('{k + 2, 10'(col)}); col++; end
      if (q.size() > 0 && q[0].due == k) begin d_r = q[0].val; void'(q.pop_front()); end
      else d_r = 10'h3FF;
    end
    chk("def_hs_first_low", 64'(hs_lo1), 64'(1));
    chk("def_hs_width", 64'(hs_hi1 - hs_lo1), 64'(96));
    chk("def_hs_period", 64'(hs_lo2 - hs_lo1), 64'(800));
    chk("def_vs_low_clocks", 64'(vs_cnt), 64'(1600));
    chk("def_framestart_count", 64'(fs_cnt), 64'(1));
    chk("def_framestart_cycle", 64'(fs_first), 64'(1));
    chk("def_first_de_cycle", 64'(de_first), 64'(1 + 35 * 800 + 144));
    chk("def_first_de_xy", 64'(first_xy), 64'(0));
    chk("def_de_per_line", 64'(de_cnt), 64'(640));
    chk("def_last_x", 64'(last_x), 64'(639));
    chk("def_first_req_cycle", 64'(req_first), 64'(35 * 800 + 142));
    chk("def_req_count", 64'(req_cnt), 64'(640));
    chk("def_red_vs_x_bad", 64'(rx_bad), 64'(0));
    chk("def_blank_vs_de_bad", 64'(blank_bad), 64'(0));
  endtask

  task automatic run_small(input int ncyc);
    int k = 0, h, v;
    logic [1:0] m = 2'd0;
    logic [60:0] e;
    sched_t q[$];
    for (int i = 0; i < ncyc; i++) begin
      h = k % 28;
      v = (k / 28) % 11;
      e = small_model(k, m, s_r, s_g, s_b);
      if (h == 0 && v == 0) m = s_mode;
      @(posedge clk); #1;
      k++;
      e[1] = small_req(k);
      chk("small_cycle", 64'({s_hs, s_vs, s_de, s_blank, s_sync, s_vr, s_vg, s_vb, s_x, s_y, s_req, s_fs}),
          64'(e));
      if (small_req(k)) q.push_back('{k + 3, 10'($urandom)});
      if (q.size() > 0 && q[0].due == k) begin
        s_r = q[0].val; s_g = ~q[0].val; s_b = q[0].val ^ 10'h2A5;
        void'(q.pop_front());
      end else begin
        s_r = 10'($urandom); s_g = 10'($urandom); s_b = 10'($urandom);
      end
      // Random mid-frame churn; a known mode is presented on each frame's latch cycle.
      s_mode = (k % 308 == 0) ? 2'((k / 308) % 4) : 2'($urandom);
    end
  endtask

  task automatic proc_small();
    run_small(4 * 308 + 5 * 28 + 12);
    rst_s_n = 1'b0;
    #1;
    chk("small_midline_reset", 64'({s_hs, s_vs, s_de, s_blank, s_sync, s_vr, s_vg, s_vb, s_x, s_y, s_req, s_fs}),
        64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    s_mode = 2'd0;
    rst_s_n = 1'b1;
    run_small(4 * 308 + 5);
  endtask

  function automatic vec_t mk(input int f, input int x, input int y, input logic [1:0] md,
                              input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    vec_t t;
    t.frame = f; t.x = x; t.y = y; t.mode = md; t.rgb = {r, g, b};
    return t;
  endfunction

  task automatic proc_bar();
    localparam logic [9:0] W = 10'h3FF;
    localparam logic [9:0] Z = 10'h000;
    vec_t tbl[$];
    int kb = 0, fc = 0;
    logic found;
    tbl.push_back(mk(0,   0, 0, 2'd1, W, W, W));
    tbl.push_back(mk(0,  79, 0, 2'd1, W, W, W));
    tbl.push_back(mk(0,  80, 0, 2'd1, W, W, Z));
    tbl.push_back(mk(0, 160, 0, 2'd1, Z, W, W));
    tbl.push_back(mk(0, 240, 0, 2'd1, Z, W, Z));
    tbl.push_back(mk(0, 320, 1, 2'd1, W, Z, W));
    tbl.push_back(mk(0, 400, 1, 2'd1, W, Z, Z));
    tbl.push_back(mk(0, 480, 1, 2'd1, Z, Z, W));
    tbl.push_back(mk(0, 560, 1, 2'd1, Z, Z, Z));
    tbl.push_back(mk(0, 639, 1, 2'd1, Z, Z, Z));
    tbl.push_back(mk(0, 100, 2, 2'd2, W, W, Z));
    tbl.push_back(mk(0,   0, 3, 2'd2, W, W, W));
    tbl.push_back(mk(1,  31, 0, 2'd2, Z, Z, Z));
    tbl.push_back(mk(1,  32, 0, 2'd2, W, W, W));
    tbl.push_back(mk(1,  63, 1, 2'd2, W, W, W));
    tbl.push_back(mk(1,  64, 1, 2'd2, Z, Z, Z));
    tbl.push_back(mk(1,  96, 2, 2'd2, W, W, W));
    tbl.push_back(mk(1, 224, 3, 2'd3, W, W, W));
    tbl.push_back(mk(2, 224, 3, 2'd3, Z, Z, Z));
    tbl.push_back(mk(3,   5, 0, 2'd0, 10'h155, 10'h0AA, 10'h2CC));
    foreach (tbl[i]) begin
      b_mode = tbl[i].mode;
      found = 1'b0;
      while (!found && kb < 24000) begin
        @(posedge clk); #1;
        kb++;
        if (b_fs) fc++;
        if (fc - 1 == tbl[i].frame && b_de && b_x == 12'(tbl[i].x) && b_y == 12'(tbl[i].y)) found = 1'b1;
      end
      if (found)
        chk($sformatf("bar_f%0d_x%0d_y%0d", tbl[i].frame, tbl[i].x, tbl[i].y),
            64'({b_vr, b_vg, b_vb}), 64'(tbl[i].rgb));
      else
        fail_timeout($sformatf("bar_f%0d_x%0d_y%0d", tbl[i].frame, tbl[i].x, tbl[i].y));
    end
  endtask

  initial begin
    rst_n = 1'b0; rst_s_n = 1'b0;
    d_mode = 2'd0; d_r = 10'h3FF; d_g = 10'h000; d_b = 10'h000;
    s_mode = 2'd0; s_r = 10'h0; s_g = 10'h0; s_b = 10'h0;
    b_mode = 2'd1; b_r = 10'h155; b_g = 10'h0AA; b_b = 10'h2CC;
    repeat (3) @(posedge clk);
    #1;
    chk("def_reset_state", 64'({d_hs, d_vs, d_de, d_blank, d_sync, d_vr, d_vg, d_vb, d_x, d_y, d_req, d_fs}),
        64'({1'b1, 1'b1, 59'b0}));
    chk("small_reset_state", 64'({s_hs, s_vs, s_de, s_blank, s_sync, s_vr, s_vg, s_vb, s_x, s_y, s_req, s_fs}),
        64'(0));
    chk("bar_reset_state", 64'({b_hs, b_vs, b_de, b_blank, b_sync, b_vr, b_vg, b_vb, b_x, b_y, b_req, b_fs}),
        64'({1'b1, 1'b1, 59'b0}));
    chk("vga_clock_follows_clk", 64'({d_vclk, s_vclk, b_vclk}), 64'({clk, clk, clk}));
    @(negedge clk);
    rst_n = 1'b1;
    rst_s_n = 1'b1;
    fork
      proc_def();
      proc_small();
      proc_bar();
    join
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
